// File: rtl/lfsr_step_gen.sv
// lfsr_step_gen: 8-bit maximal-length LFSR stepped by a debounced pushbutton
// and/or a free-running auto-step prescaler, with a synchronous seed load.
`timescale 1ns/1ps

module lfsr_step_gen #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned AUTO_DIV   = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       auto_en,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] q,
  output logic [3:0] hex_hi,
  output logic [3:0] hex_lo,
  output logic       step_pulse
);

  localparam int unsigned DEB_W = 16;
  localparam int unsigned PRE_W = 24;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

  logic             s1;
  logic             s2;
  logic             deb;
  logic             deb_d;
  logic [DEB_W-1:0] deb_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic             btn_rise;
  logic             tick;
  logic             step_req;
  logic [7:0]       lfsr_next;
  logic [7:0]       q_nxt;
  logic             pulse_nxt;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debouncer: level follows s2 only after DEB_CYCLES consecutive mismatches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb_d <= deb;
      if (s2 != deb) begin
        if (deb_cnt == DEB_LAST) begin
          deb     <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Auto-step prescaler: wraps 0..AUTO_DIV-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!auto_en) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Step request: both sources merge into one step when they coincide
  always_comb begin
    btn_rise = deb & ~deb_d;
    tick     = (pre_cnt == PRE_LAST);
    step_req = btn_rise | (auto_en & tick);
  end

  // Next LFSR value (x^8+x^4+x^3+x^2+1, right shift) with all-zero escape
  always_comb begin
    lfsr_next = 8'h01;
    if (q != 8'h00) begin
      lfsr_next = {q[4] ^ q[3] ^ q[2] ^ q[0], q[7:1]};
    end
  end

  // Load beats step beats hold; a step lost to a load is dropped
  always_comb begin
    q_nxt     = q;
    pulse_nxt = 1'b0;
    if (load) begin
      q_nxt = (seed == 8'h00) ? 8'h01 : seed;
    end else if (step_req) begin
      q_nxt     = lfsr_next;
      pulse_nxt = 1'b1;
    end
  end

  // LFSR state and step indicator registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q          <= 8'h01;
      step_pulse <= 1'b0;
    end else begin
      q          <= q_nxt;
      step_pulse <= pulse_nxt;
    end
  end

  assign hex_hi = q[7:4];
  assign hex_lo = q[3:0];

endmodule

// File: tb/tb_lfsr_step_gen.sv
// tb_lfsr_step_gen: directed scenarios plus randomized traffic, every cycle
// compared against a window-based behavioural model of the step generator.
`timescale 1ns/1ps

module tb_lfsr_step_gen;

  localparam int unsigned DEB = 4;
  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       auto_en;
  logic       load;
  logic [7:0] seed;
  logic [7:0] q;
  logic [3:0] hex_hi;
  logic [3:0] hex_lo;
  logic       step_pulse;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model state
  bit [7:0]    m_q;
  bit          m_pulse;
  bit          m_deb;
  bit          m_rise;
  int unsigned m_run;
  bit          hist[$];
  bit          s2h[$];

  // scenario bookkeeping
  int unsigned pulses;
  int unsigned steps;
  int unsigned last;
  int unsigned cyc;
  int unsigned repeats;
  int unsigned run_left;
  bit          seen[256];
  logic [7:0]  q255;
  logic [7:0]  exp_seq[4];

  always #5 clk = ~clk;

  lfsr_step_gen #(.DEB_CYCLES(DEB), .AUTO_DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .auto_en   (auto_en),
    .load      (load),
    .seed      (seed),
    .q         (q),
    .hex_hi    (hex_hi),
    .hex_lo    (hex_lo),
    .step_pulse(step_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [7:0] ref_next(input bit [7:0] v);
    int unsigned fb;
    if (v == 8'h00) return 8'h01;
    fb = 32'((v >> 4) ^ (v >> 3) ^ (v >> 2) ^ v) & 32'd1;
    return 8'((32'(v) >> 1) | (fb << 7));
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  // Debounce: level flips once the last DEB synchronized samples all differ.
  task automatic model_edge();
    bit do_step;
    bit s2cur;
    bit flip;
    if (!rst_n) begin
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      s2h.delete();
      m_deb   = 1'b0;
      m_rise  = 1'b0;
      m_run   = 0;
      m_q     = 8'h01;
      m_pulse = 1'b0;
    end else begin
      do_step = m_rise || (auto_en && ((m_run % DIV) == DIV - 1));
      if (load) begin
        m_q     = (seed == 8'h00) ? 8'h01 : seed;
        m_pulse = 1'b0;
      end else if (do_step) begin
        m_q     = ref_next(m_q);
        m_pulse = 1'b1;
      end else begin
        m_pulse = 1'b0;
      end
      s2cur = hist[hist.size() - 2];
      hist.push_back(btn);
      if (hist.size() > 8) void'(hist.pop_front());
      s2h.push_back(s2cur);
      if (s2h.size() > DEB + 4) void'(s2h.pop_front());
      flip = (s2h.size() >= DEB);
      for (int i = 0; i < int'(DEB); i++)
        if (s2h[s2h.size() - 1 - i] == m_deb) flip = 1'b0;
      m_rise = flip && !m_deb;
      if (flip) m_deb = !m_deb;
      m_run = auto_en ? m_run + 1 : 0;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("q", 32'(q), 32'(m_q));
    check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    check("hex_hi", 32'(hex_hi), 32'(m_q[7:4]));
    check("hex_lo", 32'(hex_lo), 32'(m_q[3:0]));
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n   = 1'b0;
    btn     = 1'b0;
    auto_en = 1'b0;
    load    = 1'b0;
    seed    = 8'h00;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_seq[0] = 8'h40;
    exp_seq[1] = 8'h20;
    exp_seq[2] = 8'h10;
    exp_seq[3] = 8'h88;

    // Reset values and first-press latency, then four clean presses
    do_reset(2);
    check("rst_q", 32'(q), 32'h01);
    check("rst_pulse", 32'(step_pulse), 32'h0);
    btn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k == 5) check("press_pre", 32'(q), 32'h01);
      if (k == 6) begin
        check("press_q", 32'(q), 32'h80);
        check("press_pulse", 32'(step_pulse), 32'h1);
      end
      if (k == 7) check("press_pulse_end", 32'(step_pulse), 32'h0);
    end
    for (int p = 0; p < 4; p++) begin
      btn = 1'b0;
      repeat (8) cycle();
      btn = 1'b1;
      repeat (8) cycle();
      check("press_seq", 32'(q), 32'(exp_seq[p]));
    end

    // Bounce shorter than the debounce window never steps
    do_reset(2);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      btn = ((i / 2) % 2) == 1;
      cycle();
      if (step_pulse === 1'b1) pulses++;
    end
    check("bounce_q", 32'(q), 32'h01);
    check("bounce_pulses", pulses, 0);
    btn = 1'b0;
    repeat (6) cycle();

    // Load of zero seed escapes, load coincident with a press wins
    do_reset(2);
    load = 1'b1;
    seed = 8'h00;
    cycle();
    load = 1'b0;
    check("load_zero", 32'(q), 32'h01);
    seed = 8'hA5;
    btn  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      load = (k == 6);
      cycle();
      if (k == 6 || k == 7) begin
        check("load_win_q", 32'(q), 32'hA5);
        check("load_win_pulse", 32'(step_pulse), 32'h0);
      end
    end
    load = 1'b0;
    btn  = 1'b0;
    repeat (8) cycle();

    // Button rise coincident with an auto tick yields one step
    do_reset(2);
    btn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      auto_en = (k >= 3 && k <= 6);
      cycle();
      if (k == 5) check("coinc_pre", 32'(q), 32'h01);
      if (k == 6) check("coinc_q", 32'(q), 32'h80);
      if (k == 7) check("coinc_after", 32'(q), 32'h80);
    end
    auto_en = 1'b0;
    btn     = 1'b0;
    repeat (8) cycle();

    // Auto stepping: period of 4 cycles, full 255-state cycle, no early repeat
    do_reset(2);
    auto_en = 1'b1;
    steps   = 0;
    last    = 0;
    cyc     = 0;
    repeats = 0;
    q255    = 8'h00;
    foreach (seen[i]) seen[i] = 1'b0;
    seen[1] = 1'b1;
    while (steps < 255 && cyc < 1200) begin
      cycle();
      cyc++;
      if (step_pulse === 1'b1) begin
        steps++;
        if (steps > 1) check("auto_gap", cyc - last, DIV);
        last = cyc;
        if (steps < 255 && seen[q]) repeats++;
        seen[q] = 1'b1;
        if (steps == 255) q255 = q;
      end
    end
    check("auto_steps", steps, 255);
    check("auto_wrap", 32'(q255), 32'h01);
    check("auto_repeats", repeats, 0);
    auto_en = 1'b0;
    repeat (4) cycle();

    // Reset mid-debounce abandons progress
    do_reset(2);
    btn = 1'b1;
    repeat (5) cycle();
    rst_n = 1'b0;
    btn   = 1'b0;
    cycle();
    check("midrst_q", 32'(q), 32'h01);
    check("midrst_pulse", 32'(step_pulse), 32'h0);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (20) begin
      cycle();
      if (step_pulse === 1'b1) pulses++;
    end
    check("midrst_pulses", pulses, 0);
    check("midrst_hold", 32'(q), 32'h01);

    // Button held through reset release counts as a fresh press
    btn = 1'b1;
    repeat (5) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      if (k == 5) check("held_pre", 32'(q), 32'h01);
      if (k == 6) check("held_q", 32'(q), 32'h80);
    end
    btn = 1'b0;
    repeat (8) cycle();

    // Randomized traffic against the model
    do_reset(2);
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        btn      = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 12);
      end
      run_left--;
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      load = ($urandom_range(0, 49) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
